obstacle_lane_engine: RTL and testbench

Parametrised obstacle mover for the Frogger-style playfield. It drives NB_LANES car X positions on a packed bus for the renderer and collision logic. Each lane has its own step size and direction. The tick period is derived from the score tier. Direction and step changes are latched on level-up only. One lane is updated per clock in a sequenced sweep, and completion is flagged by a done pulse.

---
 rtl/obstacle_lane_engine_if.sv | 36 +++
 rtl/obstacle_lane_engine.sv | 184 ++++++++++++++++++
 tb/tb_obstacle_lane_engine.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_lane_engine_if.sv
// obstacle_lane_engine_if
//   Control and position bus between the game controller and the obstacle
//   lane engine.
//   enable      : 1 = run the tick counter, 0 = freeze it
//   level_up    : single-cycle pulse that arms a direction/step reload
//   reverse     : per-lane direction, bit k for lane k (0 = +X, 1 = -X)
//   step        : per-lane pixels per update, lane k at [k*STEP_WIDTH +: STEP_WIDTH]
//   score       : current score, selects the speed tier
//   car_x       : lane k position at [k*X_WIDTH +: X_WIDTH]
//   update_done : one-cycle pulse when the last lane of a sweep is written
//   busy        : high while a sweep is in progress
//   Modports: master = controller side, slave = engine side.
interface obstacle_lane_engine_if #(
   parameter int unsigned NB_LANES   = 4,
   parameter int unsigned X_WIDTH    = 10,
   parameter int unsigned STEP_WIDTH = 3
);
   logic                           enable;
   logic                           level_up;
   logic [NB_LANES-1:0]            reverse;
   logic [NB_LANES*STEP_WIDTH-1:0] step;
   logic [5:0]                     score;
   logic [NB_LANES*X_WIDTH-1:0]    car_x;
   logic                           update_done;
   logic                           busy;

   modport master (
      output enable, level_up, reverse, step, score,
      input  car_x, update_done, busy
   );

   modport slave (
      input  enable, level_up, reverse, step, score,
      output car_x, update_done, busy
   );
endinterface

// File: rtl/obstacle_lane_engine.sv
// obstacle_lane_engine
//   Moves NB_LANES cars horizontally across a playfield of width
//   H_VISIBLE_AREA - TILE_SIZE. A tick counter, whose period follows the
//   score tier, starts a sweep that updates one lane per clock. Direction
//   and step changes take effect only after a level-up pulse.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : obstacle_lane_engine_if slave modport (controls in, positions out)
module obstacle_lane_engine #(
   parameter int unsigned NB_LANES       = 4,
   parameter int unsigned H_VISIBLE_AREA = 640,
   parameter int unsigned TILE_SIZE      = 32,
   parameter int unsigned BASE_TICK      = 781250,
   parameter int unsigned TICK_WIDTH     = 20,
   parameter int unsigned X_WIDTH        = 10,
   parameter int unsigned STEP_WIDTH     = 3
) (
   input logic                   clk,
   input logic                   reset,
   obstacle_lane_engine_if.slave bus
);

   localparam int unsigned SPAN = H_VISIBLE_AREA - TILE_SIZE;
   localparam int unsigned IDX_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

   localparam logic [TICK_WIDTH-1:0] PERIOD_T0 = TICK_WIDTH'(BASE_TICK);
   localparam logic [TICK_WIDTH-1:0] PERIOD_T1 = TICK_WIDTH'(BASE_TICK >> 1);
   localparam logic [TICK_WIDTH-1:0] PERIOD_T2 = TICK_WIDTH'(BASE_TICK >> 2);
   localparam logic [TICK_WIDTH-1:0] PERIOD_T3 = TICK_WIDTH'(BASE_TICK >> 3);
   localparam logic [X_WIDTH:0]      SPAN_W    = (X_WIDTH + 1)'(SPAN);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NB_LANES - 1);

   // A sweep must finish before the fastest tier can tick again.
   if ((BASE_TICK >> 3) < (NB_LANES + 1)) begin : g_bad_period
      $error("obstacle_lane_engine: fastest tick period shorter than a sweep");
   end

   typedef enum logic [0:0] {StRun, StUpdate} state_e;

   state_e                         state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [TICK_WIDTH-1:0]          cnt_q, cnt_d;
   logic [TICK_WIDTH-1:0]          period_q, period_d;
   logic                           pending_q, pending_d;
   logic [NB_LANES-1:0]            rev_q, rev_d;
   logic [NB_LANES*STEP_WIDTH-1:0] step_q, step_d;
   logic                           done_q, done_d;
   logic [X_WIDTH-1:0]             pos_q [NB_LANES];

   logic                  tick;
   logic                  lane_we;
   logic [X_WIDTH-1:0]    new_x;
   logic [X_WIDTH:0]      x_ext;
   logic [X_WIDTH:0]      s_ext;
   logic [X_WIDTH:0]      sum;
   logic [STEP_WIDTH-1:0] cur_step;
   logic                  cur_rev;

   function automatic logic [TICK_WIDTH-1:0] tier_period(input logic [5:0] score);
      if (score <= 6'd3) begin
         return PERIOD_T0;
      end else if (score <= 6'd6) begin
         return PERIOD_T1;
      end else if (score <= 6'd9) begin
         return PERIOD_T2;
      end
      return PERIOD_T3;
   endfunction

   // Tick counter; the period is re-sampled from the score only on wrap so a
   // score change never shortens or stretches an interval already running.
   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      tick     = 1'b0;
      if (bus.enable) begin
         if (cnt_q == period_q - 1'b1) begin
            cnt_d    = '0;
            tick     = 1'b1;
            period_d = tier_period(bus.score);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Sweep sequencer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q | bus.level_up;
      rev_d     = rev_q;
      step_d    = step_q;
      lane_we   = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (tick) begin
               state_d = StUpdate;
               idx_d   = '0;
               // A pulse coinciding with the tick counts for this sweep.
               if (pending_q || bus.level_up) begin
                  rev_d     = bus.reverse;
                  step_d    = bus.step;
                  pending_d = 1'b0;
               end
            end
         end
         StUpdate: begin
            lane_we = 1'b1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = StRun;
               idx_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Modulo-SPAN move of the lane currently addressed by the sweep.
   always_comb begin
      cur_step = step_q[idx_q*STEP_WIDTH +: STEP_WIDTH];
      cur_rev  = rev_q[idx_q];
      x_ext    = {1'b0, pos_q[idx_q]};
      s_ext    = {{(X_WIDTH + 1 - STEP_WIDTH){1'b0}}, cur_step};
      if (!cur_rev) begin
         sum = x_ext + s_ext;
         if (sum >= SPAN_W) begin
            sum = sum - SPAN_W;
         end
      end else if (x_ext < s_ext) begin
         sum = x_ext + SPAN_W - s_ext;
      end else begin
         sum = x_ext - s_ext;
      end
      new_x = sum[X_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StRun;
         idx_q     <= '0;
         cnt_q     <= '0;
         period_q  <= tier_period(bus.score);
         pending_q <= 1'b0;
         rev_q     <= bus.reverse;
         step_q    <= bus.step;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         pending_q <= pending_d;
         rev_q     <= rev_d;
         step_q    <= step_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(NB_LANES); k++) begin
            pos_q[k] <= X_WIDTH'((k * TILE_SIZE) % SPAN);
         end
      end else if (lane_we) begin
         pos_q[idx_q] <= new_x;
      end
   end

   always_comb begin
      bus.car_x = '0;
      for (int k = 0; k < int'(NB_LANES); k++) begin
         bus.car_x[k*X_WIDTH +: X_WIDTH] = pos_q[k];
      end
   end

   assign bus.update_done = done_q;
   assign bus.busy        = (state_q == StUpdate);

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// tb_obstacle_lane_engine
//   Self-checking bench for obstacle_lane_engine with a small playfield tick
//   (BASE_TICK = 64). Lane positions are predicted per sweep with plain
//   modulo arithmetic; timing is checked against cycle counts.
module tb_obstacle_lane_engine;

   localparam int unsigned NL   = 4;
   localparam int unsigned XW   = 10;
   localparam int unsigned SW   = 3;
   localparam int unsigned TW   = 20;
   localparam int unsigned BT   = 64;
   localparam int          SPAN = 608;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   obstacle_lane_engine_if #(.NB_LANES(NL), .X_WIDTH(XW), .STEP_WIDTH(SW)) bus ();

   obstacle_lane_engine #(
      .NB_LANES      (NL),
      .H_VISIBLE_AREA(640),
      .TILE_SIZE     (32),
      .BASE_TICK     (BT),
      .TICK_WIDTH    (TW),
      .X_WIDTH       (XW),
      .STEP_WIDTH    (SW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: positions and the active direction/step per lane.
   int mx    [NL];
   bit mrev  [NL];
   int mstep [NL];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_bus();
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < int'(NL); k++) begin
         v[k*XW +: XW] = XW'(mx[k]);
      end
      return v;
   endfunction

   function automatic logic [63:0] lane(input int k);
      return 64'(bus.car_x[k*XW +: XW]);
   endfunction

   task automatic model_init();
      for (int k = 0; k < int'(NL); k++) mx[k] = k * 32;
   endtask

   task automatic model_sweep();
      for (int k = 0; k < int'(NL); k++) begin
         if (mrev[k]) mx[k] = (mx[k] + SPAN - mstep[k]) % SPAN;
         else         mx[k] = (mx[k] + mstep[k]) % SPAN;
      end
   endtask

   task automatic drive_model_controls();
      for (int k = 0; k < int'(NL); k++) begin
         bus.reverse[k]          = mrev[k];
         bus.step[k*SW +: SW]    = SW'(mstep[k]);
      end
   endtask

   task automatic wait_busy(input string tag, input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!bus.busy && n < budget);
      check({tag, "_busy_seen"}, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!bus.update_done && n < budget);
      check({tag, "_done_seen"}, 64'(bus.update_done), 64'd1);
   endtask

   task automatic run_sweeps(input string tag, input int count);
      int n;
      for (int i = 0; i < count; i++) begin
         wait_done(tag, 200, n);
         model_sweep();
         check({tag, "_pos"}, 64'(bus.car_x), model_bus());
      end
   endtask

   int n;
   int prev_period;
   int cnt_ev;
   int tier_lo  [4] = '{4, 7, 10, 0};
   int tier_hi  [4] = '{6, 9, 63, 3};
   int tier_per [4] = '{32, 16, 8, 64};
   int old_x    [NL];
   int new_x    [NL];
   logic [63:0] exp_bus;

   initial begin
      // ---------------- reset and forward wrap ----------------
      bus.enable   = 1'b0;
      bus.level_up = 1'b0;
      bus.score    = 6'd0;
      mrev[0]  = 1'b0;
      mstep[0] = 2;
      for (int k = 1; k < int'(NL); k++) begin
         mrev[k]  = 1'($urandom_range(1, 0));
         mstep[k] = $urandom_range(7, 0);
      end
      drive_model_controls();
      model_init();
      reset = 1'b1;
      cyc();
      cyc();
      for (int k = 0; k < int'(NL); k++) check("reset_lane", lane(k), 64'(k * 32));
      check("reset_done", 64'(bus.update_done), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);

      reset      = 1'b0;
      bus.enable = 1'b1;
      wait_busy("first", 100, n);
      check("first_tick_cycles", 64'(n), 64'(BT));
      wait_done("first", 10, n);
      check("first_done_after_tick", 64'(n), 64'(NL));
      model_sweep();
      check("first_pos", 64'(bus.car_x), model_bus());
      run_sweeps("fwd", 302);
      check("fwd_lane0_303", lane(0), 64'd606);
      run_sweeps("fwd", 1);
      check("fwd_lane0_304", lane(0), 64'd0);

      // ---------------- reverse wrap via level-up ----------------
      mrev[1]  = 1'b0;
      mstep[1] = 0;
      drive_model_controls();
      model_init();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      mrev[1]  = 1'b1;
      mstep[1] = 4;
      for (int k = 0; k < int'(NL); k++) begin
         if (k != 1) begin
            mrev[k]  = 1'($urandom_range(1, 0));
            mstep[k] = $urandom_range(7, 1);
         end
      end
      drive_model_controls();
      bus.level_up = 1'b1;
      cyc();
      bus.level_up = 1'b0;
      run_sweeps("rev", 8);
      check("rev_lane1_8", lane(1), 64'd0);
      run_sweeps("rev", 1);
      check("rev_lane1_9", lane(1), 64'd604);

      // ---------------- speed tiers ----------------
      prev_period = 64;
      for (int t = 0; t < 4; t++) begin
         bus.score = 6'($urandom_range(tier_hi[t], tier_lo[t]));
         wait_done("tier_old", 200, n);
         check("tier_old_spacing", 64'(n), 64'(prev_period));
         model_sweep();
         check("tier_old_pos", 64'(bus.car_x), model_bus());
         wait_done("tier_new", 200, n);
         check("tier_new_spacing", 64'(n), 64'(tier_per[t]));
         model_sweep();
         check("tier_new_pos", 64'(bus.car_x), model_bus());
         prev_period = tier_per[t];
      end

      // ---------------- per-lane sweep timing ----------------
      wait_busy("timing", 200, n);
      for (int k = 0; k < int'(NL); k++) old_x[k] = mx[k];
      model_sweep();
      for (int k = 0; k < int'(NL); k++) new_x[k] = mx[k];
      for (int j = 0; j <= int'(NL); j++) begin
         exp_bus = '0;
         for (int k = 0; k < int'(NL); k++) begin
            exp_bus[k*XW +: XW] = XW'((k < j) ? new_x[k] : old_x[k]);
         end
         check("timing_pos", 64'(bus.car_x), exp_bus);
         check("timing_busy", 64'(bus.busy), 64'(j < int'(NL)));
         check("timing_done", 64'(bus.update_done), 64'(j == int'(NL)));
         if (j < int'(NL)) cyc();
      end

      // ---------------- pause mid-sweep ----------------
      wait_busy("pause", 200, n);
      cyc();
      bus.enable = 1'b0;
      wait_done("pause", 10, n);
      check("pause_done_cycles", 64'(n), 64'(NL - 1));
      model_sweep();
      check("pause_pos", 64'(bus.car_x), model_bus());
      cnt_ev = 0;
      for (int i = 0; i < 150; i++) begin
         cyc();
         if (bus.busy || bus.update_done) cnt_ev++;
      end
      check("pause_no_activity", 64'(cnt_ev), 64'd0);
      bus.enable = 1'b1;
      wait_busy("resume", 200, n);
      check("resume_tick_cycles", 64'(n), 64'(BT - 1));
      wait_done("resume", 10, n);
      model_sweep();
      check("resume_pos", 64'(bus.car_x), model_bus());

      // ---------------- level-up gating ----------------
      bus.reverse = 4'b1111;
      run_sweeps("nopulse", 2);
      wait_busy("lvl", 200, n);
      for (int k = 0; k < int'(NL); k++) begin
         bus.step[k*SW +: SW] = SW'($urandom_range(7, 1));
      end
      bus.level_up = 1'b1;
      cyc();
      bus.level_up = 1'b0;
      wait_done("lvl_inflight", 10, n);
      model_sweep();
      check("lvl_inflight_pos", 64'(bus.car_x), model_bus());
      for (int k = 0; k < int'(NL); k++) begin
         mrev[k]  = 1'b1;
         mstep[k] = int'(bus.step[k*SW +: SW]);
      end
      run_sweeps("lvl_after", 3);

      // ---------------- reset mid-sweep ----------------
      wait_busy("midrst", 200, n);
      cyc();
      reset = 1'b1;
      cyc();
      for (int k = 0; k < int'(NL); k++) check("midrst_lane", lane(k), 64'(k * 32));
      check("midrst_done", 64'(bus.update_done), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      reset  = 1'b0;
      cnt_ev = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.update_done) cnt_ev++;
      end
      check("midrst_no_done", 64'(cnt_ev), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
